// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundle of every bus signal around mem_arbiter: the CPU data port, the DMA
//   requester, the single-port RAM and a read-only debug view of the arbiter's
//   registered state.
//
//   Modports:
//     slave  - the arbiter. It receives requests and RAM read data. It drives
//              the grants, the stall, the read returns, the RAM controls and
//              the debug view.
//     master - the environment. It drives requests and RAM read data. It
//              observes everything else.
//
//   Handshake semantics:
//     A requester raises <x>_req together with stable <x>_we/_addr/_wdata. The
//     access is taken in any cycle where the grant is visible: ~cpu_stall for
//     the CPU, dma_gnt for the DMA. An un-granted requester keeps its fields
//     stable, or it drops req, which has no side effects. A granted read
//     returns exactly one cycle later, with <x>_rvalid high for one cycle and
//     <x>_rdata carrying the data.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 16
);
  // CPU data port
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  // DMA requester
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_lock;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;

  // Single-port synchronous RAM
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // Debug view of the registered arbitration state
  logic [3:0]    dbg_wait_cnt;
  logic [7:0]    dbg_burst_cnt;
  logic          dbg_in_burst;
  logic [1:0]    dbg_rd_owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    output dma_gnt, dma_rvalid, dma_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output dbg_wait_cnt, dbg_burst_cnt, dbg_in_burst, dbg_rd_owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  dbg_wait_cnt, dbg_burst_cnt, dbg_in_burst, dbg_rd_owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port synchronous data RAM between the CPU data port and a
//   DMA requester (screen refresh, program loader). The RAM takes one access
//   per cycle.
//
//   Priority, highest first:
//     1. an active locked DMA burst with fewer than BURST_MAX beats;
//     2. an aged DMA, i.e. both requesting and the DMA has lost MAX_WAIT
//        consecutive cycles;
//     3. the CPU;
//     4. the DMA.
//   The grant is combinational from the requests and the registered state.
//   A CPU that requests and loses is stalled in the same cycle.
//
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous active-low reset. While it is low, every output
//             is held at 0.
//     bus   - mem_arbiter_if.slave (CPU, DMA, RAM and debug signals)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW        = 15,
  parameter int DW        = 16,
  parameter int MAX_WAIT  = 4,   // 1..15
  parameter int BURST_MAX = 8    // 1..255
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter_if.slave   bus
);

  // Owner of the read issued in the previous cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam logic [3:0] WAIT_SAT  = 4'(MAX_WAIT);
  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

  logic [3:0] wait_cnt_q,  wait_cnt_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       in_burst_q,  in_burst_d;
  owner_e     rd_owner_q,  rd_owner_d;

  logic gnt_cpu;
  logic gnt_dma;

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_dma = 1'b0;
    if (in_burst_q && bus.dma_req && (burst_cnt_q < BURST_LIM)) begin
      gnt_dma = 1'b1;
    end else if (bus.cpu_req && bus.dma_req && (wait_cnt_q == WAIT_SAT)) begin
      gnt_dma = 1'b1;
    end else if (bus.cpu_req) begin
      gnt_cpu = 1'b1;
    end else if (bus.dma_req) begin
      gnt_dma = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_cnt_d  = 4'd0;
    burst_cnt_d = 8'd0;
    in_burst_d  = 1'b0;
    rd_owner_d  = OWN_NONE;

    if (gnt_dma) begin
      wait_cnt_d  = 4'd0;
      // A burst counts beats from its first grant. That first grant is the
      // one taken while in_burst was still clear.
      burst_cnt_d = in_burst_q ? (burst_cnt_q + 8'd1) : 8'd1;
      in_burst_d  = bus.dma_lock;
    end else if (bus.dma_req) begin
      // A lost cycle ends any burst and ages the DMA toward a forced win.
      wait_cnt_d  = (wait_cnt_q == WAIT_SAT) ? WAIT_SAT : (wait_cnt_q + 4'd1);
      burst_cnt_d = 8'd0;
      in_burst_d  = 1'b0;
    end

    if (gnt_cpu && !bus.cpu_we) begin
      rd_owner_d = OWN_CPU;
    end else if (gnt_dma && !bus.dma_we) begin
      rd_owner_d = OWN_DMA;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= 4'd0;
      burst_cnt_q <= 8'd0;
      in_burst_q  <= 1'b0;
      rd_owner_q  <= OWN_NONE;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      in_burst_q  <= in_burst_d;
      rd_owner_q  <= rd_owner_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // rst_n gates every output. The reason is that the grant is combinational
  // from live requests, and the requests may stay high during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.cpu_stall     = 1'b0;
    bus.cpu_rvalid    = 1'b0;
    bus.cpu_rdata     = '0;
    bus.dma_gnt       = 1'b0;
    bus.dma_rvalid    = 1'b0;
    bus.dma_rdata     = '0;
    bus.ram_en        = 1'b0;
    bus.ram_we        = 1'b0;
    bus.ram_addr      = '0;
    bus.ram_wdata     = '0;
    bus.dbg_wait_cnt  = 4'd0;
    bus.dbg_burst_cnt = 8'd0;
    bus.dbg_in_burst  = 1'b0;
    bus.dbg_rd_owner  = 2'd0;

    if (rst_n) begin
      bus.cpu_stall  = bus.cpu_req & ~gnt_cpu;
      bus.dma_gnt    = gnt_dma;
      bus.ram_en     = gnt_cpu | gnt_dma;

      // The read data path is shared. rvalid says whose result it is.
      bus.cpu_rdata  = bus.ram_rdata;
      bus.dma_rdata  = bus.ram_rdata;
      bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
      bus.dma_rvalid = (rd_owner_q == OWN_DMA);

      if (gnt_dma) begin
        bus.ram_we    = bus.dma_we;
        bus.ram_addr  = bus.dma_addr;
        bus.ram_wdata = bus.dma_wdata;
      end else if (gnt_cpu) begin
        bus.ram_we    = bus.cpu_we;
        bus.ram_addr  = bus.cpu_addr;
        bus.ram_wdata = bus.cpu_wdata;
      end

      bus.dbg_wait_cnt  = wait_cnt_q;
      bus.dbg_burst_cnt = burst_cnt_q;
      bus.dbg_in_burst  = in_burst_q;
      bus.dbg_rd_owner  = rd_owner_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with the default parameters (MAX_WAIT = 4,
//   BURST_MAX = 8).
//   Inputs are driven just after the falling edge. Outputs are sampled 1 ns
//   later, well before the next rising edge.
//   A behavioural synchronous RAM sits on the RAM side.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 15;
  localparam int DW = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4), .BURST_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural single-port synchronous RAM
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic dr, input logic dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] dd,
                       input logic dl);
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.dma_req   = dr;
    bus.dma_we    = dw;
    bus.dma_addr  = da;
    bus.dma_wdata = dd;
    bus.dma_lock  = dl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          cr, cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          dr, dw;
    logic [AW-1:0] da;
    logic [DW-1:0] dd;
    logic          dl;
    logic          e_stall, e_gnt, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_crv, e_drv;
    logic [DW-1:0] e_rdata;
    logic          chk_rd;
  } vec_t;

  vec_t vecs[14];

  localparam logic [AW-1:0] CA = 15'h0010;
  localparam logic [AW-1:0] DA = 15'h0200;

  initial begin
    //                cr cw ca   cd        dr dw da   dd        dl  stl gnt en we addr  wdata     crv drv rdata     chk
    vecs[0]  = '{1'b1,1'b1,CA,16'h1234, 1'b0,1'b0,DA,16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b1,CA,16'h1234, 1'b0,1'b0,16'h0000,1'b0};
    vecs[1]  = '{1'b1,1'b0,CA,16'h0000, 1'b0,1'b0,DA,16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b0,CA,16'h0000, 1'b0,1'b0,16'h0000,1'b0};
    vecs[2]  = '{1'b0,1'b0,CA,16'h0000, 1'b0,1'b0,DA,16'h0000,1'b0, 1'b0,1'b0,1'b0,1'b0,'0,16'h0000, 1'b1,1'b0,16'h1234,1'b1};
    vecs[3]  = '{1'b0,1'b0,CA,16'h0000, 1'b1,1'b1,DA,16'hBEEF,1'b0, 1'b0,1'b1,1'b1,1'b1,DA,16'hBEEF, 1'b0,1'b0,16'h0000,1'b0};
    vecs[4]  = '{1'b0,1'b0,CA,16'h0000, 1'b1,1'b0,DA,16'h0000,1'b0, 1'b0,1'b1,1'b1,1'b0,DA,16'h0000, 1'b0,1'b0,16'h0000,1'b0};
    vecs[5]  = '{1'b1,1'b0,CA,16'h0000, 1'b0,1'b0,DA,16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b0,CA,16'h0000, 1'b0,1'b1,16'hBEEF,1'b1};
    vecs[6]  = '{1'b0,1'b0,CA,16'h0000, 1'b0,1'b0,DA,16'h0000,1'b0, 1'b0,1'b0,1'b0,1'b0,'0,16'h0000, 1'b1,1'b0,16'h1234,1'b1};
    // contention, no lock: C C C C D C
    vecs[7]  = '{1'b1,1'b0,CA,16'h0000, 1'b1,1'b0,DA,16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b0,CA,16'h0000, 1'b0,1'b0,16'h0000,1'b0};
    vecs[8]  = '{1'b1,1'b0,CA,16'h0000, 1'b1,1'b0,DA,16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b0,CA,16'h0000, 1'b1,1'b0,16'h1234,1'b1};
    vecs[9]  = '{1'b1,1'b0,CA,16'h0000, 1'b1,1'b0,DA,16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b0,CA,16'h0000, 1'b1,1'b0,16'h1234,1'b1};
    vecs[10] = '{1'b1,1'b0,CA,16'h0000, 1'b1,1'b0,DA,16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b0,CA,16'h0000, 1'b1,1'b0,16'h1234,1'b1};
    vecs[11] = '{1'b1,1'b0,CA,16'h0000, 1'b1,1'b0,DA,16'h0000,1'b0, 1'b1,1'b1,1'b1,1'b0,DA,16'h0000, 1'b1,1'b0,16'h1234,1'b1};
    vecs[12] = '{1'b1,1'b0,CA,16'h0000, 1'b1,1'b0,DA,16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b0,CA,16'h0000, 1'b0,1'b1,16'hBEEF,1'b1};
    vecs[13] = '{1'b0,1'b0,CA,16'h0000, 1'b0,1'b0,DA,16'h0000,1'b0, 1'b0,1'b0,1'b0,1'b0,'0,16'h0000, 1'b1,1'b0,16'h1234,1'b1};
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    logic [16:0] burst_pat;
    logic        prev_d;
    int          stalls;

    // Reset with every request high
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 15'h0000, 16'h5555, 1'b1, 1'b1, 15'h0001, 16'hAAAA, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("rst cpu_stall",  bus.cpu_stall,  0);
    chk("rst dma_gnt",    bus.dma_gnt,    0);
    chk("rst ram_en",     bus.ram_en,     0);
    chk("rst ram_we",     bus.ram_we,     0);
    chk("rst ram_addr",   bus.ram_addr,   0);
    chk("rst cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst dma_rvalid", bus.dma_rvalid, 0);
    chk("rst cpu_rdata",  bus.cpu_rdata,  0);
    chk("rst wait_cnt",   bus.dbg_wait_cnt, 0);

    // Release: the first grant goes to the CPU
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel cpu_stall", bus.cpu_stall, 0);
    chk("rel dma_gnt",   bus.dma_gnt,   0);
    chk("rel ram_en",    bus.ram_en,    1);
    chk("rel ram_addr",  bus.ram_addr,  0);
    @(negedge clk);
    idle();
    #1;
    chk("rel wait_cnt", bus.dbg_wait_cnt, 1);

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
            vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd, vecs[i].dl);
      #1;
      chk($sformatf("v%0d cpu_stall", i),  bus.cpu_stall,  vecs[i].e_stall);
      chk($sformatf("v%0d dma_gnt", i),    bus.dma_gnt,    vecs[i].e_gnt);
      chk($sformatf("v%0d ram_en", i),     bus.ram_en,     vecs[i].e_en);
      chk($sformatf("v%0d ram_we", i),     bus.ram_we,     vecs[i].e_we);
      chk($sformatf("v%0d ram_addr", i),   bus.ram_addr,   vecs[i].e_addr);
      chk($sformatf("v%0d cpu_rvalid", i), bus.cpu_rvalid, vecs[i].e_crv);
      chk($sformatf("v%0d dma_rvalid", i), bus.dma_rvalid, vecs[i].e_drv);
      if (vecs[i].e_we)
        chk($sformatf("v%0d ram_wdata", i), bus.ram_wdata, vecs[i].e_wdata);
      if (vecs[i].chk_rd) begin
        exp_q.push_back(vecs[i].e_rdata);
        chk($sformatf("v%0d rdata", i),
            vecs[i].e_crv ? bus.cpu_rdata : bus.dma_rdata, exp_q.pop_front());
      end
    end

    // Locked burst with the CPU contending: 4 C, 8 D, 1 C, 3 C, then D
    burst_pat = 17'b0000_11111111_0000_1;
    prev_d    = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, CA, '0, 1'b1, 1'b0, DA, '0, 1'b1);
      #1;
      chk($sformatf("burst%0d dma_gnt", i),   bus.dma_gnt,   burst_pat[16-i]);
      chk($sformatf("burst%0d cpu_stall", i), bus.cpu_stall, burst_pat[16-i]);
      if (i > 0) begin
        chk($sformatf("burst%0d dma_rvalid", i), bus.dma_rvalid, prev_d);
        chk($sformatf("burst%0d cpu_rvalid", i), bus.cpu_rvalid, !prev_d);
      end
      if (i == 12) chk("burst cnt at limit", bus.dbg_burst_cnt, 8);
      if (i == 13) chk("burst wait restart", bus.dbg_wait_cnt, 1);
      prev_d = burst_pat[16-i];
    end
    @(negedge clk);
    idle();

    // Steady aging without lock: stall 1 in 5
    stalls = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, CA, '0, 1'b1, 1'b0, DA, '0, 1'b0);
      #1;
      chk($sformatf("age%0d cpu_stall", i), bus.cpu_stall, ((i % 5) == 4) ? 1 : 0);
      if (bus.cpu_stall) stalls++;
    end
    chk("age stall count", stalls, 3);
    @(negedge clk);
    idle();

    // Burst abort: dma_req drops on the third beat
    @(negedge clk);
    drive(1'b0, 1'b0, CA, '0, 1'b1, 1'b0, 15'h0300, '0, 1'b1);
    #1;
    chk("abort beat1 gnt", bus.dma_gnt, 1);
    @(negedge clk);
    drive(1'b1, 1'b0, CA, '0, 1'b1, 1'b0, 15'h0300, '0, 1'b1);
    #1;
    chk("abort beat2 gnt",    bus.dma_gnt,    1);
    chk("abort beat2 stall",  bus.cpu_stall,  1);
    chk("abort beat2 rvalid", bus.dma_rvalid, 1);
    @(negedge clk);
    drive(1'b1, 1'b0, CA, '0, 1'b0, 1'b0, 15'h0300, '0, 1'b1);
    #1;
    chk("abort beat3 gnt",    bus.dma_gnt,    0);
    chk("abort beat3 stall",  bus.cpu_stall,  0);
    chk("abort beat3 addr",   bus.ram_addr,   CA);
    chk("abort beat3 rvalid", bus.dma_rvalid, 1);
    @(negedge clk);
    idle();
    #1;
    chk("abort end cpu_rvalid", bus.cpu_rvalid,   1);
    chk("abort end cpu_rdata",  bus.cpu_rdata,    16'h1234);
    chk("abort end dma_rvalid", bus.dma_rvalid,   0);
    chk("abort end in_burst",   bus.dbg_in_burst, 0);
    chk("abort end burst_cnt",  bus.dbg_burst_cnt, 0);

    // Reset while a DMA read is being granted
    @(negedge clk);
    drive(1'b0, 1'b1, CA, 16'h0000, 1'b1, 1'b0, 15'h0300, '0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, CA, '0, 1'b1, 1'b0, 15'h0100, '0, 1'b1);
    #1;
    chk("rstrd gnt",      bus.dma_gnt,       1);
    chk("rstrd in_burst", bus.dbg_in_burst,  1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstrd dma_rvalid in rst", bus.dma_rvalid, 0);
    @(negedge clk);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("rstrd%0d dma_rvalid", i), bus.dma_rvalid,    0);
      chk($sformatf("rstrd%0d wait_cnt", i),   bus.dbg_wait_cnt,  0);
      chk($sformatf("rstrd%0d burst_cnt", i),  bus.dbg_burst_cnt, 0);
      chk($sformatf("rstrd%0d in_burst", i),   bus.dbg_in_burst,  0);
      chk($sformatf("rstrd%0d rd_owner", i),   bus.dbg_rd_owner,  0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single-port data RAM between two requesters: the CPU data port and a DMA requester (screen refresh, program loader).
- Sits between the CPU's memory outputs and the RAM.
- Stalls the CPU on cycles it loses arbitration.
- Uses CPU-first priority, with aging so the DMA is never starved, and a bounded DMA burst lock.

## Interface
Parameters:
- AW, 15, address width (matches CPU data address).
- DW, 16, data width.
- MAX_WAIT, 4, number of consecutive lost cycles after which the DMA wins a contended cycle (1..15).
- BURST_MAX, 8, maximum consecutive locked DMA grants (1..255).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU wants a RAM access this cycle.
- cpu_we  in  1  CPU access is a write.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_stall  out  1  cpu_req high but not granted; CPU must hold its state.
- cpu_rvalid  out  1  cpu_rdata valid this cycle.
- cpu_rdata  out  DW  read data for the CPU.
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/AW/DW  DMA request fields, same meaning as the CPU fields.
- dma_lock  in  1  request to keep the grant on following cycles (burst).
- dma_gnt  out  1  DMA access accepted this cycle.
- dma_rvalid  out  1  dma_rdata valid this cycle.
- dma_rdata  out  DW  read data for the DMA.
- ram_en, ram_we  out  1  RAM enable / write strobe.
- ram_addr, ram_wdata  out  AW/DW  RAM address / write data.
- ram_rdata  in  DW  RAM synchronous read data, valid one cycle after a read enable.

## Operation
- One RAM access per cycle.
- Grant is combinational from the requests and the registered state.
- The winner's fields are muxed to the RAM; ram_en = any grant; ram_we = winner's we.

Registered state:
- wait_cnt: 4 bits, saturates at MAX_WAIT.
- burst_cnt: 8 bits.
- in_burst: 1 bit.
- rd_owner: 2 bits; NONE/CPU/DMA, records the owner of the read issued last cycle.

Grant decision, in priority order:
- BURST: in_burst and dma_req and burst_cnt < BURST_MAX → DMA.
- AGED: cpu_req and dma_req and wait_cnt == MAX_WAIT → DMA.
- CPU: cpu_req → CPU.
- DMA: dma_req → DMA.
- Otherwise idle: ram_en = 0.

State update each edge:
- DMA granted:
  - wait_cnt ← 0.
  - burst_cnt ← burst_cnt + 1 if in_burst, else 1.
  - in_burst ← dma_lock.
- DMA requested but not granted: wait_cnt ← min(wait_cnt + 1, MAX_WAIT); in_burst ← 0; burst_cnt ← 0.
- No DMA request: wait_cnt ← 0; in_burst ← 0; burst_cnt ← 0.
- rd_owner ← winner if a read was granted, else NONE.

Read return:
- cpu_rdata and dma_rdata both carry ram_rdata continuously.
- cpu_rvalid = (rd_owner == CPU); dma_rvalid = (rd_owner == DMA).
- cpu_stall = cpu_req & ~CPU grant.

## Timing
- Reset (rst_n low, asynchronous): wait_cnt = 0, burst_cnt = 0, in_burst = 0, rd_owner = NONE.
- While rst_n is low, every output is forced to 0, including cpu_stall, grants, ram_en and ram_we.
- Grant/stall latency: 0 cycles, same cycle as the request. The write lands at the next edge.
- Read latency: data and rvalid appear exactly 1 cycle after the grant. Back-to-back reads give one result per cycle.
- Requester rule: a requester holds its request fields stable until granted. Withdrawing a request before grant is allowed and has no side effects.
- Contended steady state (both requesting, no lock): CPU for MAX_WAIT cycles, DMA for 1 cycle, repeating.
- Locked burst with CPU also requesting: at most BURST_MAX consecutive DMA grants, then one CPU cycle guaranteed. After that cycle wait_cnt restarts from 1.
- dma_req falling during a burst ends the burst the same cycle; the CPU can be granted in that cycle.
- dma_lock low on a granted beat: that beat is the last locked beat.
- Reset asserted with a read in flight: the result is discarded and no rvalid is emitted after release.

## Test plan
- Reset: hold rst_n = 0 with all requests high → every output is 0. Release → the first grant goes to the CPU; cpu_stall = 0.
- CPU write then read: write 0x1234 to 0x0010; next cycle read 0x0010 → ram_we = 1 on cycle 0; cpu_rvalid = 1 with cpu_rdata = 0x1234 on cycle 2; dma_rvalid stays 0.
- Aging: cpu_req and dma_req held high, dma_lock = 0, MAX_WAIT = 4 → grants repeat C,C,C,C,D. cpu_stall is high only on the D cycles, 1 in 5.
- Burst bound: as the aging test but dma_lock = 1, BURST_MAX = 8 → after 4 CPU cycles, 8 consecutive DMA grants, then exactly 1 CPU grant, then the DMA waits 4 cycles again.
- Burst abort: during a locked burst, drop dma_req at beat 3 → that cycle grants the CPU; in_burst = 0; dma_rvalid follows only the granted reads.
- Reset mid-read: grant a DMA read at 0x0100, assert rst_n low before the next edge → dma_rvalid never asserts; counters read 0 after release.
